// File: rtl/cartoon_pkg.sv
// Shared types and helpers for the cartoonifier tile DMA sequencer.
// Holds the tile FSM state type, tile-count helper and the tile address function.
package cartoon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    FILT  = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } tile_state_t;

  function automatic int unsigned tiles_of(input int unsigned img, input int unsigned blk);
    return img / blk;
  endfunction

  // Computed 64 bits wide; callers truncate to ADDR_W, which gives the modulo-2^ADDR_W wrap.
  function automatic logic [63:0] tile_addr(input logic [63:0] base,
                                            input int unsigned tx, input int unsigned ty,
                                            input int unsigned r, input int unsigned c,
                                            input int unsigned img_w, input int unsigned blk_w,
                                            input int unsigned blk_h, input int unsigned pix_bytes);
    logic [63:0] pix;
    pix = 64'(ty) * 64'(blk_h) + 64'(r);
    pix = pix * 64'(img_w) + 64'(tx) * 64'(blk_w) + 64'(c);
    return base + pix * 64'(pix_bytes);
  endfunction

endpackage

// File: rtl/tile_dma_if.sv
// Avalon-MM command/response bundle between the tile sequencer and the SDRAM port.
interface tile_dma_if #(parameter int ADDR_W = 32);

  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic              m_waitrequest;
  logic              m_readdatavalid;
  logic              m_writeresponsevalid;

  modport master (
    output m_address, m_read, m_write,
    input  m_waitrequest, m_readdatavalid, m_writeresponsevalid
  );

  modport slave (
    input  m_address, m_read, m_write,
    output m_waitrequest, m_readdatavalid, m_writeresponsevalid
  );

endinterface

// File: rtl/tile_addr_gen.sv
// Pixel (c, r) and tile (tx, ty) position counters shared by the read and write phases.
module tile_addr_gen #(
  parameter int BLK_W   = 8,
  parameter int BLK_H   = 8,
  parameter int TILES_X = 80,
  parameter int TILES_Y = 60,
  parameter int CW      = $clog2(BLK_W + 1),
  parameter int RW      = $clog2(BLK_H + 1),
  parameter int TXW     = $clog2(TILES_X + 1),
  parameter int TYW     = $clog2(TILES_Y + 1)
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           clear,
  input  logic           adv_pix,
  input  logic           adv_tile,
  output logic [CW-1:0]  c,
  output logic [RW-1:0]  r,
  output logic [TXW-1:0] tx,
  output logic [TYW-1:0] ty,
  output logic           pix_last,
  output logic           tx_last,
  output logic           ty_last
);

  logic c_last_s;
  logic r_last_s;

  assign c_last_s = (c == CW'(BLK_W - 1));
  assign r_last_s = (r == RW'(BLK_H - 1));
  assign pix_last = c_last_s & r_last_s;
  assign tx_last  = (tx == TXW'(TILES_X - 1));
  assign ty_last  = (ty == TYW'(TILES_Y - 1));

  // Raster advance inside a tile (c fastest) and across tiles (tx fastest).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      c  <= {CW{1'b0}};
      r  <= {RW{1'b0}};
      tx <= {TXW{1'b0}};
      ty <= {TYW{1'b0}};
    end else if (clear) begin
      c  <= {CW{1'b0}};
      r  <= {RW{1'b0}};
      tx <= {TXW{1'b0}};
      ty <= {TYW{1'b0}};
    end else begin
      if (adv_pix) begin
        if (c_last_s) begin
          c <= {CW{1'b0}};
          r <= r_last_s ? {RW{1'b0}} : r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end
      if (adv_tile) begin
        if (tx_last) begin
          tx <= {TXW{1'b0}};
          ty <= ty_last ? {TYW{1'b0}} : ty + TYW'(1);
        end else begin
          tx <= tx + TXW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tile_dma_ctrl.sv
// Tile sequencer: reads each BLK_W x BLK_H tile, waits for the filter, writes it back.
// Optional CARTOON_PERF_CNT_EN adds the stall_cycles waitrequest counter.
module tile_dma_ctrl
  import cartoon_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int BLK_W     = 8,
  parameter int BLK_H     = 8,
  parameter int PIX_BYTES = 4,
  parameter int ADDR_W    = 32,
  parameter int MAX_PEND  = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  tile_dma_if.master        bus,
  output logic              load_pixel,
  output logic              tile_loaded,
  input  logic              filter_done,
  output logic              shift_write,
  output logic              busy,
  output logic              done
`ifdef CARTOON_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int TILES_X = tiles_of(IMG_W, BLK_W);
  localparam int TILES_Y = tiles_of(IMG_H, BLK_H);
  localparam int NPIX    = BLK_W * BLK_H;
  localparam int PW      = $clog2(MAX_PEND + 1);
  localparam int NW      = $clog2(NPIX + 1);
  localparam int CW      = $clog2(BLK_W + 1);
  localparam int RW      = $clog2(BLK_H + 1);
  localparam int TXW     = $clog2(TILES_X + 1);
  localparam int TYW     = $clog2(TILES_Y + 1);

  if ((IMG_W % BLK_W) != 0) begin : g_chk_w
    $error("IMG_W must be a multiple of BLK_W");
  end
  if ((IMG_H % BLK_H) != 0) begin : g_chk_h
    $error("IMG_H must be a multiple of BLK_H");
  end
  if (MAX_PEND < 1) begin : g_chk_pend
    $error("MAX_PEND must be at least 1");
  end

  tile_state_t       state_r, state_s;
  logic [ADDR_W-1:0] src_r, dst_r, addr_s;
  logic [PW-1:0]     pend_r;
  logic [NW-1:0]     ret_cnt_r;
  logic              rd_all_r, wr_wait_r, wr_last_r;
  logic              rd_cmd_s, wr_cmd_s, rd_acc_s, rd_ret_s, wr_acc_s, wr_rsp_s;
  logic              start_acc_s, clear_s, adv_pix_s, adv_tile_s, tl_s, done_s;
  logic [CW-1:0]     c_s;
  logic [RW-1:0]     r_s;
  logic [TXW-1:0]    tx_s;
  logic [TYW-1:0]    ty_s;
  logic              pix_last_s, tx_last_s, ty_last_s;

  tile_addr_gen #(
    .BLK_W(BLK_W), .BLK_H(BLK_H), .TILES_X(TILES_X), .TILES_Y(TILES_Y),
    .CW(CW), .RW(RW), .TXW(TXW), .TYW(TYW)
  ) u_addr_gen (
    .clk(clk), .n_rst(n_rst), .clear(clear_s), .adv_pix(adv_pix_s), .adv_tile(adv_tile_s),
    .c(c_s), .r(r_s), .tx(tx_s), .ty(ty_s),
    .pix_last(pix_last_s), .tx_last(tx_last_s), .ty_last(ty_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, bus commands and per-cycle event strobes.
  always_comb begin
    state_s     = state_r;
    rd_cmd_s    = 1'b0;
    wr_cmd_s    = 1'b0;
    rd_acc_s    = 1'b0;
    rd_ret_s    = 1'b0;
    wr_acc_s    = 1'b0;
    wr_rsp_s    = 1'b0;
    start_acc_s = 1'b0;
    clear_s     = 1'b0;
    adv_pix_s   = 1'b0;
    adv_tile_s  = 1'b0;
    tl_s        = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          clear_s     = 1'b1;
          state_s     = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        rd_cmd_s  = !rd_all_r && (pend_r != PW'(MAX_PEND));
        rd_acc_s  = rd_cmd_s && !bus.m_waitrequest;
        adv_pix_s = rd_acc_s;
        rd_ret_s  = bus.m_readdatavalid && (pend_r != PW'(0));
        if (rd_ret_s && (ret_cnt_r == NW'(NPIX - 1))) begin
          tl_s    = 1'b1;
          state_s = FILT;
        end else begin
          state_s = READ;
        end
      end
      FILT: begin
        if (filter_done) begin
          state_s = WRITE;
        end else begin
          state_s = FILT;
        end
      end
      WRITE: begin
        // A single write in flight: the next one waits for the response.
        wr_cmd_s  = !wr_wait_r;
        wr_acc_s  = wr_cmd_s && !bus.m_waitrequest;
        adv_pix_s = wr_acc_s;
        wr_rsp_s  = bus.m_writeresponsevalid && wr_wait_r;
        if (wr_rsp_s && wr_last_r) begin
          state_s = NEXT;
        end else begin
          state_s = WRITE;
        end
      end
      NEXT: begin
        adv_tile_s = 1'b1;
        if (tx_last_s && ty_last_s) begin
          state_s = DONE;
        end else begin
          state_s = READ;
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Frame bases, read pipeline bookkeeping and write handshake flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      src_r     <= {ADDR_W{1'b0}};
      dst_r     <= {ADDR_W{1'b0}};
      pend_r    <= {PW{1'b0}};
      ret_cnt_r <= {NW{1'b0}};
      rd_all_r  <= 1'b0;
      wr_wait_r <= 1'b0;
      wr_last_r <= 1'b0;
    end else if (start_acc_s) begin
      src_r     <= src_base;
      dst_r     <= dst_base;
      pend_r    <= {PW{1'b0}};
      ret_cnt_r <= {NW{1'b0}};
      rd_all_r  <= 1'b0;
      wr_wait_r <= 1'b0;
      wr_last_r <= 1'b0;
    end else begin
      case ({rd_acc_s, rd_ret_s})
        2'b10:   pend_r <= pend_r + PW'(1);
        2'b01:   pend_r <= pend_r - PW'(1);
        default: pend_r <= pend_r;
      endcase
      if (tl_s) begin
        ret_cnt_r <= {NW{1'b0}};
        rd_all_r  <= 1'b0;
      end else begin
        if (rd_ret_s) ret_cnt_r <= ret_cnt_r + NW'(1);
        if (rd_acc_s && pix_last_s) rd_all_r <= 1'b1;
      end
      if (wr_acc_s) begin
        wr_wait_r <= 1'b1;
        if (pix_last_s) wr_last_r <= 1'b1;
      end else if (wr_rsp_s) begin
        wr_wait_r <= 1'b0;
        if (wr_last_r) wr_last_r <= 1'b0;
      end
    end
  end

  // Command address; forced to zero when no command is presented.
  always_comb begin
    if (rd_cmd_s) begin
      addr_s = ADDR_W'(tile_addr(64'(src_r), 32'(tx_s), 32'(ty_s), 32'(r_s), 32'(c_s),
                                 IMG_W, BLK_W, BLK_H, PIX_BYTES));
    end else if (wr_cmd_s) begin
      addr_s = ADDR_W'(tile_addr(64'(dst_r), 32'(tx_s), 32'(ty_s), 32'(r_s), 32'(c_s),
                                 IMG_W, BLK_W, BLK_H, PIX_BYTES));
    end else begin
      addr_s = {ADDR_W{1'b0}};
    end
  end

  assign bus.m_address = addr_s;
  assign bus.m_read    = rd_cmd_s;
  assign bus.m_write   = wr_cmd_s;
  assign load_pixel    = rd_ret_s;
  assign tile_loaded   = tl_s;
  assign shift_write   = wr_acc_s;
  assign done          = done_s;
  assign busy          = (state_r != IDLE) && (state_r != DONE);

`ifdef CARTOON_PERF_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of command cycles stalled by waitrequest.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt_r <= 32'd0;
    end else if (start_acc_s) begin
      stall_cnt_r <= 32'd0;
    end else if ((rd_cmd_s | wr_cmd_s) && bus.m_waitrequest && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_tile_dma_ctrl.sv
// Randomised bench for tile_dma_ctrl on a 16x8 image of 8x8 tiles with MAX_PEND=2.
// The reference is a raster pixel-address list plus a simple Avalon slave model.
module tb_tile_dma_ctrl;

  localparam int IW = 16, IH = 8, BW = 8, BH = 8, PB = 4, MP = 2;
  localparam int NPIX = BW * BH;
  localparam int NT   = (IW / BW) * (IH / BH);
  localparam int TOT  = NPIX * NT;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        filter_done = 1'b0;
  logic [31:0] src_base = 32'd0;
  logic [31:0] dst_base = 32'd0;
  logic        load_pixel, tile_loaded, shift_write, busy, done;
`ifdef CARTOON_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  tile_dma_if #(.ADDR_W(32)) bus();

  tile_dma_ctrl #(
    .IMG_W(IW), .IMG_H(IH), .BLK_W(BW), .BLK_H(BH),
    .PIX_BYTES(PB), .ADDR_W(32), .MAX_PEND(MP)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .bus(bus), .load_pixel(load_pixel), .tile_loaded(tile_loaded), .filter_done(filter_done),
    .shift_write(shift_write), .busy(busy), .done(done)
`ifdef CARTOON_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_rd[$];
  logic [31:0] exp_wr[$];
  int          ret_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected command addresses: every pixel of every tile, tiles in raster order.
  task automatic build_model(input logic [31:0] s, input logic [31:0] d);
    int x, y;
    exp_rd.delete();
    exp_wr.delete();
    for (int t = 0; t < NT; t++) begin
      for (int rr = 0; rr < BH; rr++) begin
        for (int cc = 0; cc < BW; cc++) begin
          x = (t % (IW / BW)) * BW + cc;
          y = (t / (IW / BW)) * BH + rr;
          exp_rd.push_back(s + 32'((y * IW + x) * PB));
          exp_wr.push_back(d + 32'((y * IW + x) * PB));
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_read"}, bus.m_read, 0);
    check({tag, "_m_write"}, bus.m_write, 0);
    check({tag, "_m_address"}, bus.m_address, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_tile_loaded"}, tile_loaded, 0);
    check({tag, "_shift_write"}, shift_write, 0);
    check({tag, "_load_pixel"}, load_pixel, 0);
  endtask

  task automatic clear_inputs();
    start = 1'b0;
    filter_done = 1'b0;
    bus.m_waitrequest = 1'b0;
    bus.m_readdatavalid = 1'b0;
    bus.m_writeresponsevalid = 1'b0;
  endtask

  // Mid-frame reset, then stray Avalon returns that the idle controller must ignore.
  task automatic do_reset();
    @(posedge clk); #1;
    n_rst = 1'b0;
    clear_inputs();
    ret_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero("in_reset");
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    bus.m_readdatavalid = 1'b1;
    bus.m_writeresponsevalid = 1'b1;
    @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_m_read", bus.m_read, 0);
    check("stray_load_pixel", load_pixel, 0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // wmode: 0 no stall, 1 random 50%, 2 first 7 command cycles stalled.
  // lmode: read latency 0 -> 1, 1 -> random 1..5, 2 -> 5.  fmode: 0 filter_done pulse, 1 held high.
  task automatic run_frame(input logic [31:0] s, input logic [31:0] d, input int wmode,
                           input int lmode, input int fmode, input int rst_at, input bit busy_start);
    int rd_acc = 0, wr_acc = 0, rets_tile = 0, iss_tile = 0, wr_ack = 0, wr_due = -1;
    int done_cnt = 0, filt_at = -1, tl_cyc = -1, max_out = 0, outst = 0, stall_left = 7;
    int done_cyc = -1, lat;
    bit prev_rd_stall = 0, prev_wr_stall = 0, first_wr_tile = 1, fin = 0, want_tl, want_load;
    logic [31:0] prev_addr = 32'd0;
    build_model(s, d);
    ret_q.delete();
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start    = (cyc == 0) || (busy_start && cyc == 40);
      src_base = (cyc == 0) ? s : 32'hDEAD_0000;
      dst_base = (cyc == 0) ? d : 32'hBEEF_0000;
      bus.m_waitrequest = (wmode == 1) ? 1'($urandom_range(0, 1)) :
                          (wmode == 2) ? (stall_left > 0) : 1'b0;
      bus.m_readdatavalid = (ret_q.size() > 0) && (ret_q[0] <= cyc);
      bus.m_writeresponsevalid = (wr_due >= 0) && (wr_due <= cyc);
      filter_done = (fmode == 1) ? 1'b1 : (cyc == filt_at);
      @(negedge clk);
      check("rd_wr_excl", bus.m_read & bus.m_write, 0);
      if (!bus.m_read && !bus.m_write) check("addr_zero_idle", bus.m_address, 0);
      if (prev_rd_stall) begin
        check("rd_hold", bus.m_read, 1);
        check("rd_addr_hold", bus.m_address, prev_addr);
      end
      if (prev_wr_stall) begin
        check("wr_hold", bus.m_write, 1);
        check("wr_addr_hold", bus.m_address, prev_addr);
      end
      prev_rd_stall = bus.m_read && bus.m_waitrequest;
      prev_wr_stall = bus.m_write && bus.m_waitrequest;
      prev_addr = bus.m_address;
      if (outst == MP) check("rd_drop_at_max_pend", bus.m_read, 0);
      if (iss_tile == NPIX) check("rd_drop_all_issued", bus.m_read, 0);
      if (bus.m_write) check("wr_single_outstanding", wr_due, -1);
      if (wmode == 2 && (bus.m_read || bus.m_write) && bus.m_waitrequest) stall_left--;
      want_tl = 0;
      want_load = 0;
      if (bus.m_readdatavalid) begin
        void'(ret_q.pop_front());
        outst--;
        rets_tile++;
        want_load = 1;
        if (rets_tile == NPIX) begin
          want_tl = 1;
          rets_tile = 0;
          iss_tile = 0;
          tl_cyc = cyc;
          filt_at = cyc + 3;
          first_wr_tile = 1;
        end
      end
      check("load_pixel", load_pixel, want_load);
      check("tile_loaded", tile_loaded, want_tl);
      if (bus.m_read && !bus.m_waitrequest) begin
        check("busy_during_read", busy, 1);
        if (exp_rd.size() == 0) check("rd_count_over", rd_acc, TOT - 1);
        else check("rd_addr", bus.m_address, exp_rd.pop_front());
        if (rd_acc == 0) check("first_rd_addr", bus.m_address, s);
        if (rd_acc == NPIX) check("tile1_first_rd", bus.m_address, s + 32'(BW * PB));
        rd_acc++;
        iss_tile++;
        outst++;
        if (outst > max_out) max_out = outst;
        lat = (lmode == 0) ? 1 : (lmode == 1) ? int'($urandom_range(1, 5)) : 5;
        ret_q.push_back(cyc + lat);
      end
      if (bus.m_writeresponsevalid) begin
        wr_due = -1;
        wr_ack++;
      end
      if (bus.m_write && !bus.m_waitrequest) begin
        check("shift_write", shift_write, 1);
        if (exp_wr.size() == 0) check("wr_count_over", wr_acc, TOT - 1);
        else check("wr_addr", bus.m_address, exp_wr.pop_front());
        if (wr_acc == 0) check("first_wr_addr", bus.m_address, d);
        if (fmode == 1 && first_wr_tile) check("filt_one_cycle", cyc - tl_cyc, 2);
        first_wr_tile = 0;
        wr_acc++;
        wr_due = cyc + ((wmode == 1) ? int'($urandom_range(1, 3)) : 1);
        if (rst_at > 0 && wr_acc == rst_at) begin
          do_reset();
          return;
        end
      end else begin
        check("shift_write_idle", shift_write, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_after_all_acks", wr_ack, TOT);
        check("busy_low_at_done", busy, 0);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) fin = 1;
    end
    check("frame_finished", fin, 1);
    check("done_once", done_cnt, 1);
    check("reads_total", rd_acc, TOT);
    check("writes_total", wr_acc, TOT);
    check("busy_after_done", busy, 0);
    check("pend_le_max", max_out <= MP, 1);
    if (lmode == 2) check("pend_reaches_max", max_out, MP);
  endtask

  initial begin
    clear_inputs();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    n_rst = 1'b1;
    run_frame(32'h0000_1000, 32'h0000_8000, 0, 0, 0, 0, 1'b0);
    run_frame(32'h0000_1000, 32'h0000_8000, 1, 1, 0, 0, 1'b1);
    run_frame(32'h0000_1000, 32'h0000_8000, 0, 2, 0, 0, 1'b0);
    run_frame(32'h0000_1000, 32'h0000_8000, 0, 0, 1, 0, 1'b0);
    run_frame(32'h0000_1000, 32'h0000_8000, 0, 1, 0, 10, 1'b0);
    run_frame(32'h0000_2000, 32'h0000_9000, 0, 0, 0, 0, 1'b0);
    run_frame(32'hFFFF_FFC0, $urandom, 1, 1, 0, 0, 1'b0);
`ifdef CARTOON_PERF_CNT_EN
    run_frame(32'h0000_1000, 32'h0000_8000, 2, 0, 0, 0, 1'b0);
    check("stall_cycles", stall_cycles, 7);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
